hnf_tag_ctrl: RTL and testbench

- Requester-side controller for the HN-F tag SRAM.
- Clears every tag set after reset, then serves lookup and update requests from the cache pipeline.
- Drives the SRAM index, read-enable, write-ways and write-cline signals; samples the registered per-way read clines.
- Returns hit, hit way, line state and a replacement victim per lookup.

---
 rtl/hnf_tag_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_hnf_tag_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hnf_tag_ctrl.sv
// Requester-side controller for the HN-F tag SRAM: clears every set after reset,
// then serves one lookup or update at a time and reports hit, state and victim.
module hnf_tag_ctrl #(
  parameter int INDEX_WIDTH = 9,
  parameter int WAY_NUM     = 4,
  parameter int CLINE_WIDTH = 28,
  parameter int STATE_WIDTH = 2,
  parameter int RD_LAT      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_op,
  input  logic [INDEX_WIDTH-1:0]          req_index,
  input  logic [CLINE_WIDTH-STATE_WIDTH-1:0] req_tag,
  input  logic [STATE_WIDTH-1:0]          req_state,
  input  logic [WAY_NUM-1:0]              req_way,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic                            resp_hit,
  output logic [WAY_NUM-1:0]              resp_hit_way,
  output logic [STATE_WIDTH-1:0]          resp_state,
  output logic [WAY_NUM-1:0]              resp_victim_way,
  output logic                            resp_multi_hit,
  output logic                            init_done,
  output logic [INDEX_WIDTH-1:0]          loc_index_q,
  output logic                            loc_rd_en_q,
  output logic [WAY_NUM-1:0]              loc_wr_ways_q,
  output logic [CLINE_WIDTH-1:0]          loc_wr_cline_q,
  input  logic [CLINE_WIDTH*WAY_NUM-1:0]  loc_rd_clines_q
);

  localparam int TAG_WIDTH  = CLINE_WIDTH - STATE_WIDTH;
  localparam int RR_WIDTH   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int WAIT_WIDTH = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD_WAIT, S_WR, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_WIDTH-1:0]  init_cnt_q, init_cnt_d;
  logic [WAIT_WIDTH-1:0]   wait_q, wait_d;
  logic [RR_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;

  logic [INDEX_WIDTH-1:0]  index_d;
  logic                    rd_en_d;
  logic [WAY_NUM-1:0]      wr_ways_d;
  logic [CLINE_WIDTH-1:0]  wr_cline_d;
  logic                    resp_valid_d, hit_d, multi_d, init_done_d;
  logic [WAY_NUM-1:0]      hit_way_d, victim_d;
  logic [STATE_WIDTH-1:0]  resp_state_d;

  logic [CLINE_WIDTH-1:0]  rd_entry [WAY_NUM];
  logic [WAY_NUM-1:0]      match, invalid, match_low, invalid_low, rr_onehot, victim_sel;
  logic [STATE_WIDTH-1:0]  hit_state;
  logic                    multi_match, use_rr;

  assign req_ready = (state_q == S_IDLE) && !resp_valid;

  // Tag compare on the registered read data; the lowest matching way supplies the state.
  always_comb begin
    match     = '0;
    invalid   = '0;
    hit_state = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      rd_entry[i] = loc_rd_clines_q[i*CLINE_WIDTH +: CLINE_WIDTH];
      invalid[i]  = (rd_entry[i][STATE_WIDTH-1:0] == '0);
      match[i]    = !invalid[i] && (rd_entry[i][CLINE_WIDTH-1:STATE_WIDTH] == tag_q);
      if (match[i]) hit_state = rd_entry[i][STATE_WIDTH-1:0];
    end
    match_low   = match & (~match + WAY_NUM'(1));
    invalid_low = invalid & (~invalid + WAY_NUM'(1));
    multi_match = |(match & (match - WAY_NUM'(1)));
    rr_onehot   = WAY_NUM'(1) << rr_ptr_q;
    use_rr      = !(|match) && !(|invalid);
    victim_sel  = (|match) ? match_low : ((|invalid) ? invalid_low : rr_onehot);
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wait_d       = wait_q;
    rr_ptr_d     = rr_ptr_q;
    tag_d        = tag_q;
    index_d      = loc_index_q;
    rd_en_d      = loc_rd_en_q;
    wr_ways_d    = loc_wr_ways_q;
    wr_cline_d   = loc_wr_cline_q;
    resp_valid_d = resp_valid;
    hit_d        = resp_hit;
    hit_way_d    = resp_hit_way;
    resp_state_d = resp_state;
    victim_d     = resp_victim_way;
    multi_d      = resp_multi_hit;
    init_done_d  = init_done;

    case (state_q)
      // loc_index_q always equals the counter here, so reset already presents set 0.
      S_INIT: begin
        if (init_cnt_q == '1) begin
          wr_ways_d   = '0;
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + INDEX_WIDTH'(1);
          index_d    = init_cnt_q + INDEX_WIDTH'(1);
          wr_ways_d  = '1;
          wr_cline_d = '0;
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready) begin
          index_d = req_index;
          if (req_op) begin
            wr_ways_d  = req_way;
            wr_cline_d = {req_tag, req_state};
            state_d    = S_WR;
          end else begin
            rd_en_d = 1'b1;
            tag_d   = req_tag;
            wait_d  = WAIT_WIDTH'(RD_LAT);
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        rd_en_d = 1'b0;
        if (wait_q == '0) begin
          resp_valid_d = 1'b1;
          hit_d        = |match;
          hit_way_d    = match;
          resp_state_d = hit_state;
          victim_d     = victim_sel;
          multi_d      = multi_match;
          if (use_rr) begin
            rr_ptr_d = (rr_ptr_q == RR_WIDTH'(WAY_NUM - 1)) ? '0 : rr_ptr_q + RR_WIDTH'(1);
          end
          state_d = S_RESP;
        end else begin
          wait_d = wait_q - WAIT_WIDTH'(1);
        end
      end
      S_WR: begin
        wr_ways_d    = '0;
        resp_valid_d = 1'b1;
        hit_d        = 1'b0;
        hit_way_d    = '0;
        resp_state_d = '0;
        victim_d     = '0;
        multi_d      = 1'b0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_INIT;
      init_cnt_q      <= '0;
      wait_q          <= '0;
      rr_ptr_q        <= '0;
      tag_q           <= '0;
      loc_index_q     <= '0;
      loc_rd_en_q     <= 1'b0;
      loc_wr_ways_q   <= '1;
      loc_wr_cline_q  <= '0;
      resp_valid      <= 1'b0;
      resp_hit        <= 1'b0;
      resp_hit_way    <= '0;
      resp_state      <= '0;
      resp_victim_way <= '0;
      resp_multi_hit  <= 1'b0;
      init_done       <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      wait_q          <= wait_d;
      rr_ptr_q        <= rr_ptr_d;
      tag_q           <= tag_d;
      loc_index_q     <= index_d;
      loc_rd_en_q     <= rd_en_d;
      loc_wr_ways_q   <= wr_ways_d;
      loc_wr_cline_q  <= wr_cline_d;
      resp_valid      <= resp_valid_d;
      resp_hit        <= hit_d;
      resp_hit_way    <= hit_way_d;
      resp_state      <= resp_state_d;
      resp_victim_way <= victim_d;
      resp_multi_hit  <= multi_d;
      init_done       <= init_done_d;
    end
  end

endmodule

// File: tb/tb_hnf_tag_ctrl.sv
// Bench for hnf_tag_ctrl: behavioural tag-store model plus SRAM model, with a
// scoreboard queue drained by a monitor on every consumed response.
module tb_hnf_tag_ctrl;

  localparam int IW   = 4;
  localparam int WN   = 4;
  localparam int CW   = 28;
  localparam int SW   = 2;
  localparam int RL   = 2;
  localparam int TW   = CW - SW;
  localparam int SETS = 1 << IW;

  logic            clk, rst;
  logic            req_valid, req_ready, req_op;
  logic [IW-1:0]   req_index;
  logic [TW-1:0]   req_tag;
  logic [SW-1:0]   req_state;
  logic [WN-1:0]   req_way;
  logic            resp_valid, resp_ready, resp_hit, resp_multi_hit, init_done;
  logic [WN-1:0]   resp_hit_way, resp_victim_way;
  logic [SW-1:0]   resp_state;
  logic [IW-1:0]   loc_index_q;
  logic            loc_rd_en_q;
  logic [WN-1:0]   loc_wr_ways_q;
  logic [CW-1:0]   loc_wr_cline_q;
  logic [CW*WN-1:0] loc_rd_clines_q;

  hnf_tag_ctrl #(
    .INDEX_WIDTH(IW), .WAY_NUM(WN), .CLINE_WIDTH(CW), .STATE_WIDTH(SW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_tag(req_tag), .req_state(req_state), .req_way(req_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_hit_way(resp_hit_way), .resp_state(resp_state),
    .resp_victim_way(resp_victim_way), .resp_multi_hit(resp_multi_hit),
    .init_done(init_done), .loc_index_q(loc_index_q), .loc_rd_en_q(loc_rd_en_q),
    .loc_wr_ways_q(loc_wr_ways_q), .loc_wr_cline_q(loc_wr_cline_q),
    .loc_rd_clines_q(loc_rd_clines_q)
  );

  typedef struct packed {
    logic          hit;
    logic [WN-1:0] hit_way;
    logic [SW-1:0] st;
    logic [WN-1:0] victim;
    logic          multi;
  } resp_t;

  int        tests = 0;
  int        fails = 0;
  resp_t     exp_q[$];
  logic [CW-1:0] model [SETS][WN];
  int        rr = 0;
  int        rmode = 2;
  resp_t     cur_resp, held;
  bit        stalled = 1'b0;
  bit        seeded = 1'b0;
  logic [CW-1:0]    mem [SETS][WN];
  logic [CW*WN-1:0] rd_pipe [RL];
  logic [TW-1:0]    tag_pool [3];

  assign cur_resp = {resp_hit, resp_hit_way, resp_state, resp_victim_way, resp_multi_hit};
  assign loc_rd_clines_q = rd_pipe[RL-1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  // SRAM model: powers up with garbage, per-way writes, RL-stage registered read.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WN; w++) mem[s][w] <= CW'($urandom);
      seeded <= 1'b1;
    end
    for (int w = 0; w < WN; w++)
      if (loc_wr_ways_q[w]) mem[loc_index_q][w] <= loc_wr_cline_q;
    if (loc_rd_en_q)
      for (int w = 0; w < WN; w++) rd_pipe[0][w*CW +: CW] <= mem[loc_index_q][w];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       resp_ready = ($urandom_range(0, 3) != 0);
        1:       resp_ready = 1'b0;
        default: resp_ready = 1'b1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic resp_t model_lookup(input int idx, input logic [TW-1:0] tag);
    resp_t r = '0;
    int hits = 0;
    int first = -1;
    int first_free = -1;
    logic [CW-1:0] e;
    for (int w = 0; w < WN; w++) begin
      e = model[idx][w];
      if (e[SW-1:0] != 0 && e[CW-1:SW] == tag) begin
        hits++;
        r.hit_way[w] = 1'b1;
        if (first < 0) first = w;
      end
      if (e[SW-1:0] == 0 && first_free < 0) first_free = w;
    end
    r.hit   = (hits > 0);
    r.multi = (hits > 1);
    if (first >= 0) begin
      e        = model[idx][first];
      r.st     = e[SW-1:0];
      r.victim = WN'(1) << first;
    end else if (first_free >= 0) begin
      r.victim = WN'(1) << first_free;
    end else begin
      r.victim = WN'(1) << rr;
      rr = (rr + 1) % WN;
    end
    return r;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WN; w++) model[s][w] = '0;
    rr = 0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      stalled <= 1'b0;
    end else begin
      checkOutput("rd_wr_exclusive", 64'(loc_rd_en_q && (|loc_wr_ways_q)), 0);
      if (stalled) checkOutput("resp_hold", {resp_valid, cur_resp}, {1'b1, held});
      if (resp_valid) begin
        checkOutput("req_ready_busy", 64'(req_ready), 0);
        if (resp_ready) begin
          stalled <= 1'b0;
          if (exp_q.size() == 0) checkOutput("resp_unexpected", 1, 0);
          else checkOutput("resp", cur_resp, exp_q.pop_front());
        end else begin
          stalled <= 1'b1;
          held    <= cur_resp;
        end
      end else begin
        stalled <= 1'b0;
      end
    end
  end

  task automatic waitIdle();
    int budget = 0;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input bit op, input int idx, input logic [TW-1:0] tag,
                               input logic [SW-1:0] st, input logic [WN-1:0] way);
    int budget = 0;
    @(posedge clk);
    #1;
    req_op = op; req_index = IW'(idx); req_tag = tag; req_state = st; req_way = way;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      checkOutput("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (op) begin
      for (int w = 0; w < WN; w++)
        if (way[w]) model[idx][w] = {tag, st};
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_lookup(idx, tag));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (op) begin
      checkOutput("upd_issue", {loc_index_q, loc_wr_ways_q, loc_wr_cline_q, loc_rd_en_q},
                  {IW'(idx), way, tag, st, 1'b0});
      @(posedge clk);
      #1;
      checkOutput("upd_one_cycle", 64'(loc_wr_ways_q), 0);
    end else begin
      checkOutput("lkp_issue", {loc_index_q, loc_rd_en_q, loc_wr_ways_q}, {IW'(idx), 1'b1, WN'(0)});
      @(posedge clk);
      #1;
      checkOutput("lkp_rd_pulse", {loc_index_q, loc_rd_en_q, resp_valid}, {IW'(idx), 2'b00});
      @(posedge clk);
      #1;
      checkOutput("lkp_lat_early", 64'(resp_valid), 0);
      @(posedge clk);
      #1;
      checkOutput("lkp_lat_a3", 64'(resp_valid), 1);
    end
  endtask

  task automatic checkReset();
    logic [51:0] rexp;
    rexp = {IW'(0), 1'b0, {WN{1'b1}}, CW'(0), 1'b0, 1'b0, WN'(0), SW'(0), WN'(0), 1'b0, 1'b0, 1'b0};
    checkOutput("reset_values",
                {loc_index_q, loc_rd_en_q, loc_wr_ways_q, loc_wr_cline_q, resp_valid, resp_hit,
                 resp_hit_way, resp_state, resp_victim_way, resp_multi_hit, init_done, req_ready},
                rexp);
  endtask

  // Called right after rst falls at a negedge; follows the sweep edge by edge.
  task automatic checkSweep();
    int nonzero = 0;
    for (int i = 0; i < SETS; i++) begin
      checkOutput("init_sweep", {loc_index_q, loc_wr_ways_q, loc_wr_cline_q, req_ready, init_done},
                  {IW'(i), {WN{1'b1}}, CW'(0), 2'b00});
      @(posedge clk);
      #1;
    end
    checkOutput("init_end", {init_done, loc_wr_ways_q, req_ready}, {1'b1, WN'(0), 1'b1});
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WN; w++)
        if (mem[s][w] != 0) nonzero++;
    checkOutput("sram_cleared", 64'(nonzero), 0);
  endtask

  initial begin
    int budget;
    tag_pool[0] = 26'h123456;
    tag_pool[1] = 26'h2ABCDE;
    tag_pool[2] = 26'h00F0F1;
    model_clear();
    rst = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_index = '0; req_tag = '0; req_state = '0; req_way = '0;
    repeat (2) @(negedge clk);
    checkReset();
    rst = 1'b0;
    checkSweep();

    rmode = 2;
    applyStimulus(1'b1, 5, 26'h123456, 2'd2, 4'b0100);
    applyStimulus(1'b0, 5, 26'h123456, 2'd0, 4'b0000);
    applyStimulus(1'b1, 7, 26'h000AAA, 2'd1, 4'b0001);
    applyStimulus(1'b1, 7, 26'h000BBB, 2'd3, 4'b0010);
    applyStimulus(1'b0, 7, 26'h000CCC, 2'd0, 4'b0000);
    for (int w = 0; w < WN; w++)
      applyStimulus(1'b1, 9, 26'h100 + TW'(w), 2'd1, WN'(1) << w);
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b0, 9, 26'h3FFFFF, 2'd0, 4'b0000);
    applyStimulus(1'b1, 3, 26'h0ABCDE, 2'd1, 4'b0001);
    applyStimulus(1'b1, 3, 26'h0ABCDE, 2'd3, 4'b0010);
    applyStimulus(1'b0, 3, 26'h0ABCDE, 2'd0, 4'b0000);
    applyStimulus(1'b1, 3, 26'h0ABCDE, 2'd2, 4'b0000);
    applyStimulus(1'b0, 3, 26'h0ABCDE, 2'd0, 4'b0000);

    // Back-pressure: hold resp_ready low for five cycles after the response appears.
    waitIdle();
    rmode = 1;
    applyStimulus(1'b0, 5, 26'h123456, 2'd0, 4'b0000);
    repeat (5) begin
      @(posedge clk);
      #2;
      checkOutput("stall_state", {resp_valid, req_ready}, 2'b10);
    end
    rmode = 2;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    checkOutput("stall_release", {resp_valid, req_ready}, 2'b01);

    rmode = 0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1)
        applyStimulus(1'b1, $urandom_range(0, 3), tag_pool[$urandom_range(0, 2)],
                      SW'($urandom_range(0, 3)), WN'($urandom_range(0, 15)));
      else
        applyStimulus(1'b0, $urandom_range(0, 3), tag_pool[$urandom_range(0, 2)], 2'd0, 4'b0000);
    end

    // Reset while a lookup is waiting on read data.
    rmode = 2;
    waitIdle();
    @(posedge clk);
    #1;
    req_op = 1'b0; req_index = 4'd5; req_tag = 26'h123456; req_valid = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_accept", 64'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkReset();
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    checkSweep();
    applyStimulus(1'b0, 5, 26'h123456, 2'd0, 4'b0000);

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
